shape_menu_fsm: RTL and testbench
=================================

Name: shape_menu_fsm

Overview:
- Navigation controller between the debounced push-button filters and the figure-drawing stage.
- Consumes the five filtered buttons (up/down/left/right/select) and keeps a cursor on a 3x3 grid of figures.
- Drives the nine one-hot figure-select lines and the full-screen flag that the drawing stage uses to choose what to render.
- Runs on the system clock; all outputs are registered.

Parameters:
- WRAP, 1, 1 = cursor wraps at grid edges; 0 = cursor clamps at grid edges.
- REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat step (used only with the optional feature).
- REPEAT_RATE, 5000000, cycles between later auto-repeat steps (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- up  input  1  debounced level, already synchronous to clk
- down  input  1  debounced level
- left  input  1  debounced level
- right  input  1  debounced level
- select  input  1  debounced level
- circle_select  output  1  grid index 0 (row 0, col 0)
- square_select  output  1  index 1
- triangle_select  output  1  index 2
- oval_select  output  1  index 3
- rectangle_select  output  1  index 4
- diamond_select  output  1  index 5
- hexagon_select  output  1  index 6
- pentagon_select  output  1  index 7
- star_select  output  1  index 8
- full_screen  output  1  1 while the chosen figure is shown full-screen
- cursor_idx  output  4  current grid index 0..8, for debug/LEDs

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = BROWSE, cursor = 0.
  - circle_select = 1, other selects = 0, full_screen = 0, cursor_idx = 0.
  - All edge-detect history registers are cleared to 0.
- Edge detection:
  - Each button has a prev register; press = level & ~prev.
  - Holding a button produces exactly one press.
- Latency: a press first sampled at clock edge k updates the state at edge k. Outputs show the new value in the cycle after edge k.
- Grid: row = idx/3, col = idx%3. The cursor is held as separate 2-bit row and col; idx = row*3 + col.
- State BROWSE:
  - Exactly one select line, the one for the cursor, is high; full_screen = 0.
  - up: row-1. down: row+1. left: col-1. right: col+1.
  - Edges with WRAP=1: row/col 0 minus 1 gives 2; 2 plus 1 gives 0. Column moves never change the row.
  - Edges with WRAP=0: the value holds at 0 or 2.
  - A select press goes to FULL.
- State FULL:
  - full_screen = 1; the select line of the chosen figure stays high.
  - Direction presses are ignored and not queued.
  - A select press returns to BROWSE with the cursor unchanged.
- Simultaneous presses in one cycle:
  - select has priority over every direction.
  - Among directions only one is applied, in priority up > down > left > right.
  - Ignored presses are consumed; they do not act in the next cycle.
- A button held through reset release does not generate a press; prev is loaded from the level in the first cycle after reset.
- Reset mid-operation, including in FULL: all values return to their reset values on the next edge.
- Invariant: exactly one of the nine select outputs is high in every cycle.

Optional Feature:
- Macro: MENU_AUTOREPEAT_EN.
- Defined:
  - Each direction held alone in BROWSE starts a 26-bit hold counter.
  - The first repeat step fires after REPEAT_DELAY cycles, then one step every REPEAT_RATE cycles.
  - Releasing the button, pressing another button, or entering FULL clears the counter.
  - select never auto-repeats.
- Not defined: no counter logic; behaviour is edge-only as described above.

Test Plan:
- Reset then idle 10 cycles -> circle_select=1, full_screen=0, cursor_idx=0.
- WRAP=1: from idx 0, pulse left, then up -> idx 2, then idx 8; star_select=1 only.
- WRAP=0: from idx 0, pulse up and left, 3 cycles each -> idx stays 0; then 2x right and 2x down -> idx 8.
- At idx 4, press select -> full_screen=1 next cycle, rectangle_select=1. Pulse right -> idx stays 4. Press select -> full_screen=0, idx 4.
- up+right+select asserted in the same cycle from idx 4 -> FULL, idx 4. Next, up+right together -> idx 1 only.
- Assert rst while in FULL at idx 7 with up held -> next cycle idx 0, BROWSE. No move while up stays held after reset.
- With MENU_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=4: hold right 20 cycles from idx 0 -> steps at hold cycles 0, 8, 12, 16 -> idx 0,1,2,0,1.

Source files
------------

// File: rtl/shape_menu_fsm.sv
`default_nettype none
// ============================================================================
// Module   : shape_menu_fsm
// Brief    : Cursor navigation over a 3x3 figure grid with one-hot figure
//            select lines and a full-screen toggle. Button presses are
//            rising-edge detected; all outputs are registered.
// Options  : MENU_AUTOREPEAT_EN - hold-to-repeat for direction buttons
// Revision : 1.0 - initial release
// ============================================================================
module shape_menu_fsm #(
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       select,
  output logic       circle_select,
  output logic       square_select,
  output logic       triangle_select,
  output logic       oval_select,
  output logic       rectangle_select,
  output logic       diamond_select,
  output logic       hexagon_select,
  output logic       pentagon_select,
  output logic       star_select,
  output logic       full_screen,
  output logic [3:0] cursor_idx
);

  typedef enum logic [0:0] {
    BROWSE = 1'b0,
    FULL   = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [4:0] prev_q;
  logic       armed_q;
  logic [8:0] sel_q, sel_d;
  logic       full_q;
  logic [3:0] idx_q, idx_d;

  // Button vector ordering: {select, up, down, left, right}
  logic [4:0] lvl;
  logic [4:0] press;
  logic       rep_fire;
  logic       step_up, step_down, step_left, step_right;

  assign lvl = {select, up, down, left, right};
  // armed_q is low for the first cycle after reset so a button held through
  // reset release only loads prev and never registers as a press.
  assign press = lvl & ~prev_q & {5{armed_q}};

  function automatic logic [1:0] dec2(input logic [1:0] v);
    if (v == 2'd0) return (WRAP != 0) ? 2'd2 : 2'd0;
    return v - 2'd1;
  endfunction

  function automatic logic [1:0] inc2(input logic [1:0] v);
    if (v >= 2'd2) return (WRAP != 0) ? 2'd0 : 2'd2;
    return v + 2'd1;
  endfunction

`ifdef MENU_AUTOREPEAT_EN
  logic [25:0] hold_q, hold_d;
  logic        rep_q, rep_d;
  logic        dir_alone;

  assign dir_alone = (state_q == BROWSE) && !select && $onehot(lvl[3:0]);

  // Hold counter: starts on a lone direction press, fires a step after the
  // initial delay and then at the repeat rate; anything else clears it.
  always_comb begin
    hold_d   = '0;
    rep_d    = 1'b0;
    rep_fire = 1'b0;
    if (armed_q && dir_alone) begin
      if (|press[3:0]) begin
        hold_d = 26'd1;
      end else if (hold_q != '0) begin
        if ((!rep_q && hold_q == 26'(REPEAT_DELAY)) ||
            ( rep_q && hold_q == 26'(REPEAT_RATE))) begin
          rep_fire = 1'b1;
          hold_d   = 26'd1;
          rep_d    = 1'b1;
        end else begin
          hold_d = hold_q + 26'd1;
          rep_d  = rep_q;
        end
      end
    end
  end

  // Hold counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign rep_fire   = 1'b0;
`endif

  // A repeat step only ever applies to the single direction being held.
  assign step_up    = press[3] | (rep_fire & up);
  assign step_down  = press[2] | (rep_fire & down);
  assign step_left  = press[1] | (rep_fire & left);
  assign step_right = press[0] | (rep_fire & right);

  // Next state, cursor movement with select > up > down > left > right
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      BROWSE: begin
        if (press[4])        state_d = FULL;
        else if (step_up)    row_d   = dec2(row_q);
        else if (step_down)  row_d   = inc2(row_q);
        else if (step_left)  col_d   = dec2(col_q);
        else if (step_right) col_d   = inc2(col_q);
      end
      FULL: begin
        if (press[4]) state_d = BROWSE;
      end
      default: state_d = BROWSE;
    endcase
    idx_d = {1'b0, row_d, 1'b0} + {2'b00, row_d} + {2'b00, col_d};
    sel_d = 9'd1 << idx_d;
  end

  // State, cursor, edge history and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BROWSE;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      prev_q  <= 5'd0;
      armed_q <= 1'b0;
      sel_q   <= 9'd1;
      full_q  <= 1'b0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      prev_q  <= lvl;
      armed_q <= 1'b1;
      sel_q   <= sel_d;
      full_q  <= (state_d == FULL);
      idx_q   <= idx_d;
    end
  end

  assign circle_select    = sel_q[0];
  assign square_select    = sel_q[1];
  assign triangle_select  = sel_q[2];
  assign oval_select      = sel_q[3];
  assign rectangle_select = sel_q[4];
  assign diamond_select   = sel_q[5];
  assign hexagon_select   = sel_q[6];
  assign pentagon_select  = sel_q[7];
  assign star_select      = sel_q[8];
  assign full_screen      = full_q;
  assign cursor_idx       = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_shape_menu_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_shape_menu_fsm
// Brief    : Directed bench for shape_menu_fsm driving a wrapping and a
//            clamping instance with the same buttons. Expected cursor and
//            full-screen values are queued with each step and checked after
//            the clock edge. Define MENU_AUTOREPEAT_EN to add the hold test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shape_menu_fsm;

  localparam logic [4:0] B_NO = 5'b00000;
  localparam logic [4:0] B_SE = 5'b10000;
  localparam logic [4:0] B_UP = 5'b01000;
  localparam logic [4:0] B_DN = 5'b00100;
  localparam logic [4:0] B_LF = 5'b00010;
  localparam logic [4:0] B_RT = 5'b00001;

  typedef struct {
    string      tag;
    logic [3:0] i1;
    logic       f1;
    logic [3:0] i0;
    logic       f0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, select = 1'b0;

  logic [8:0] sel1, sel0;
  logic       fs1, fs0;
  logic [3:0] idx1, idx0;

  int vectors     = 0;
  int miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  shape_menu_fsm #(.WRAP(1), .REPEAT_DELAY(8), .REPEAT_RATE(4)) u_wrap (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .select(select),
    .circle_select(sel1[0]), .square_select(sel1[1]), .triangle_select(sel1[2]),
    .oval_select(sel1[3]), .rectangle_select(sel1[4]), .diamond_select(sel1[5]),
    .hexagon_select(sel1[6]), .pentagon_select(sel1[7]), .star_select(sel1[8]),
    .full_screen(fs1), .cursor_idx(idx1)
  );

  shape_menu_fsm #(.WRAP(0), .REPEAT_DELAY(8), .REPEAT_RATE(4)) u_clamp (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .select(select),
    .circle_select(sel0[0]), .square_select(sel0[1]), .triangle_select(sel0[2]),
    .oval_select(sel0[3]), .rectangle_select(sel0[4]), .diamond_select(sel0[5]),
    .hexagon_select(sel0[6]), .pentagon_select(sel0[7]), .star_select(sel0[8]),
    .full_screen(fs0), .cursor_idx(idx0)
  );

  task automatic cmp(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    logic [8:0] oh1, oh0;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
      return;
    end
    e   = sb.pop_front();
    oh1 = 9'd1 << e.i1;
    oh0 = 9'd1 << e.i0;
    cmp({e.tag, ".wrap.idx"},  {5'd0, idx0 & 4'h0 | idx1}, {5'd0, e.i1});
    cmp({e.tag, ".wrap.full"}, {8'd0, fs1},  {8'd0, e.f1});
    cmp({e.tag, ".wrap.sel"},  sel1, oh1);
    cmp({e.tag, ".clamp.idx"}, {5'd0, idx0}, {5'd0, e.i0});
    cmp({e.tag, ".clamp.full"},{8'd0, fs0},  {8'd0, e.f0});
    cmp({e.tag, ".clamp.sel"}, sel0, oh0);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, check.
  task automatic step(input string tag, input logic r, input logic [4:0] b,
                      input int i1, input int f1, input int i0, input int f0);
    exp_t e;
    @(negedge clk);
    rst = r;
    {select, up, down, left, right} = b;
    e.tag = tag;
    e.i1  = 4'(i1);
    e.f1  = (f1 != 0);
    e.i0  = 4'(i0);
    e.f0  = (f0 != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // Reset and idle
    step("rst0", 1'b1, B_NO, 0, 0, 0, 0);
    step("rst1", 1'b1, B_NO, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("idle", 1'b0, B_NO, 0, 0, 0, 0);

    // Edges from idx 0: wrap goes 0 -> 2 -> 8, clamp stays at 0
    step("left_edge", 1'b0, B_LF, 2, 0, 0, 0);
    step("rel",       1'b0, B_NO, 2, 0, 0, 0);
    step("up_edge",   1'b0, B_UP, 8, 0, 0, 0);
    step("rel",       1'b0, B_NO, 8, 0, 0, 0);

    // Fresh start, held buttons act once
    step("rst",    1'b1, B_NO, 0, 0, 0, 0);
    step("arm",    1'b0, B_NO, 0, 0, 0, 0);
    step("up_h0",  1'b0, B_UP, 6, 0, 0, 0);
    step("up_h1",  1'b0, B_UP, 6, 0, 0, 0);
    step("up_h2",  1'b0, B_UP, 6, 0, 0, 0);
    step("rel",    1'b0, B_NO, 6, 0, 0, 0);
    step("lf_h0",  1'b0, B_LF, 8, 0, 0, 0);
    step("lf_h1",  1'b0, B_LF, 8, 0, 0, 0);
    step("lf_h2",  1'b0, B_LF, 8, 0, 0, 0);
    step("rel",    1'b0, B_NO, 8, 0, 0, 0);
    step("rt1",    1'b0, B_RT, 6, 0, 1, 0);
    step("rel",    1'b0, B_NO, 6, 0, 1, 0);
    step("rt2",    1'b0, B_RT, 7, 0, 2, 0);
    step("rel",    1'b0, B_NO, 7, 0, 2, 0);
    step("dn1",    1'b0, B_DN, 1, 0, 5, 0);
    step("rel",    1'b0, B_NO, 1, 0, 5, 0);
    step("dn2",    1'b0, B_DN, 4, 0, 8, 0);
    step("rel",    1'b0, B_NO, 4, 0, 8, 0);
    step("rt_edge",1'b0, B_RT, 5, 0, 8, 0);
    step("rel",    1'b0, B_NO, 5, 0, 8, 0);
    step("dn_edge",1'b0, B_DN, 8, 0, 8, 0);
    step("rel",    1'b0, B_NO, 8, 0, 8, 0);

    // Navigate both to idx 4 and exercise FULL
    step("rst",    1'b1, B_NO, 0, 0, 0, 0);
    step("arm",    1'b0, B_NO, 0, 0, 0, 0);
    step("to1",    1'b0, B_RT, 1, 0, 1, 0);
    step("rel",    1'b0, B_NO, 1, 0, 1, 0);
    step("to4",    1'b0, B_DN, 4, 0, 4, 0);
    step("rel",    1'b0, B_NO, 4, 0, 4, 0);
    step("sel_in", 1'b0, B_SE, 4, 1, 4, 1);
    step("rel",    1'b0, B_NO, 4, 1, 4, 1);
    step("full_rt",1'b0, B_RT, 4, 1, 4, 1);
    step("rel",    1'b0, B_NO, 4, 1, 4, 1);
    step("sel_out",1'b0, B_SE, 4, 0, 4, 0);
    step("rel",    1'b0, B_NO, 4, 0, 4, 0);

    // Simultaneous presses
    step("ur_sel", 1'b0, B_UP | B_RT | B_SE, 4, 1, 4, 1);
    step("rel",    1'b0, B_NO, 4, 1, 4, 1);
    step("sel_out",1'b0, B_SE, 4, 0, 4, 0);
    step("rel",    1'b0, B_NO, 4, 0, 4, 0);
    step("ur",     1'b0, B_UP | B_RT, 1, 0, 1, 0);
    step("ur_hold",1'b0, B_UP | B_RT, 1, 0, 1, 0);
    step("rel",    1'b0, B_NO, 1, 0, 1, 0);
    step("rel",    1'b0, B_NO, 1, 0, 1, 0);

    // Reset while in FULL at idx 7 with up held
    step("to4",    1'b0, B_DN, 4, 0, 4, 0);
    step("rel",    1'b0, B_NO, 4, 0, 4, 0);
    step("to7",    1'b0, B_DN, 7, 0, 7, 0);
    step("rel",    1'b0, B_NO, 7, 0, 7, 0);
    step("sel_in", 1'b0, B_SE, 7, 1, 7, 1);
    step("rel",    1'b0, B_NO, 7, 1, 7, 1);
    step("full_up",1'b0, B_UP, 7, 1, 7, 1);
    step("rst_up", 1'b1, B_UP, 0, 0, 0, 0);
    step("post0",  1'b0, B_UP, 0, 0, 0, 0);
    step("post1",  1'b0, B_UP, 0, 0, 0, 0);
    step("post2",  1'b0, B_UP, 0, 0, 0, 0);
    step("rel",    1'b0, B_NO, 0, 0, 0, 0);
    step("up_new", 1'b0, B_UP, 6, 0, 0, 0);
    step("rel",    1'b0, B_NO, 6, 0, 0, 0);

`ifdef MENU_AUTOREPEAT_EN
    // Hold right 20 cycles: steps at hold cycles 0, 8, 12, 16
    step("rst",    1'b1, B_NO, 0, 0, 0, 0);
    step("arm",    1'b0, B_NO, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      int e1, e0;
      e1 = (i < 8) ? 1 : (i < 12) ? 2 : (i < 16) ? 0 : 1;
      e0 = (i < 8) ? 1 : 2;
      step("rpt_rt", 1'b0, B_RT, e1, 0, e0, 0);
    end
    step("rel",    1'b0, B_NO, 1, 0, 2, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
